// File: rtl/decode_stage.sv
// RV32I ALU-subset decode: registers alu_op/imm/rd/pc and regfile read addresses for execute, one cycle latency.
// Backpressure: id_ready drops while execute holds the output register, on flush, or on a RAW hazard against the pending-write scoreboard.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    input  logic            flush,
    input  logic            ex_ready,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    output logic            id_ex_valid,
    output logic [3:0]      id_ex_alu_op,
    output logic [XLEN-1:0] id_ex_imm,
    output logic            id_ex_input_a_is_immediate,
    output logic [4:0]      id_ex_rd,
    output logic [XLEN-1:0] id_ex_pc,
    output logic            id_ex_illegal,
    output logic [4:0]      regfile_rd0_addr,
    output logic [4:0]      regfile_rd1_addr
);

    typedef enum logic [3:0] {
        ALU_NONE = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_SLTU = 4'd10
    } alu_op_e;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;

    assign opcode = if_instr[6:0];
    assign rd     = if_instr[11:7];
    assign funct3 = if_instr[14:12];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];
    assign funct7 = if_instr[31:25];

    alu_op_e         dec_op;
    logic [XLEN-1:0] dec_imm;
    logic            dec_a_imm;
    logic [4:0]      dec_rd;
    logic            dec_ill;
    logic            use_rs1;
    logic            use_rs2;

    always_comb begin
        dec_op    = ALU_NONE;
        dec_imm   = '0;
        dec_a_imm = 1'b0;
        dec_rd    = '0;
        dec_ill   = 1'b1;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                dec_ill   = 1'b0;
                use_rs1   = 1'b1;
                dec_rd    = rd;
                dec_a_imm = 1'b1;
                dec_imm   = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
                case (funct3)
                    3'b000:  dec_op = ALU_ADD;
                    3'b010:  dec_op = ALU_SLT;
                    3'b011:  dec_op = ALU_SLTU;
                    3'b100:  dec_op = ALU_XOR;
                    3'b110:  dec_op = ALU_OR;
                    3'b111:  dec_op = ALU_AND;
                    3'b001: begin
                        dec_op  = ALU_SLL;
                        dec_imm = {{(XLEN-5){1'b0}}, if_instr[24:20]};
                        dec_ill = (funct7 != F7_ZERO) && (funct7 != F7_ALT);
                    end
                    default: begin
                        dec_op  = if_instr[30] ? ALU_SRA : ALU_SRL;
                        dec_imm = {{(XLEN-5){1'b0}}, if_instr[24:20]};
                        dec_ill = (funct7 != F7_ZERO) && (funct7 != F7_ALT);
                    end
                endcase
            end
            OPC_OP: begin
                // Only base RV32I encodings: funct7 0100000 exists just for SUB and SRA.
                dec_ill = !((funct7 == F7_ZERO) ||
                            ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                dec_rd  = rd;
                case (funct3)
                    3'b000:  dec_op = if_instr[30] ? ALU_SUB : ALU_ADD;
                    3'b001:  dec_op = ALU_SLL;
                    3'b010:  dec_op = ALU_SLT;
                    3'b011:  dec_op = ALU_SLTU;
                    3'b100:  dec_op = ALU_XOR;
                    3'b101:  dec_op = if_instr[30] ? ALU_SRA : ALU_SRL;
                    3'b110:  dec_op = ALU_OR;
                    default: dec_op = ALU_AND;
                endcase
            end
            OPC_LUI: begin
                dec_ill   = 1'b0;
                dec_op    = ALU_ADD;
                dec_rd    = rd;
                dec_a_imm = 1'b1;
                dec_imm   = {{(XLEN-31){if_instr[31]}}, if_instr[30:12], 12'b0};
            end
            default: ;
        endcase
        if (dec_ill) begin
            dec_op    = ALU_NONE;
            dec_imm   = '0;
            dec_a_imm = 1'b0;
            dec_rd    = '0;
            use_rs1   = 1'b0;
            use_rs2   = 1'b0;
        end
    end

    logic            valid_q;
    alu_op_e         alu_op_q;
    logic [XLEN-1:0] imm_q;
    logic            a_imm_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] pc_q;
    logic            ill_q;
    logic [4:0]      ra0_q;
    logic [4:0]      ra1_q;
    logic [NREGS-1:0] sb_q;
    logic [NREGS-1:0] sb_d;

    logic rs1_busy;
    logic rs2_busy;
    logic hazard;
    logic load;
    logic issue;
    logic sb_set;

    // A source is busy while its producer sits in the output register or awaits writeback.
    assign rs1_busy = (rs1 != 5'd0) && (sb_q[rs1] || (valid_q && (rd_q == rs1)));
    assign rs2_busy = (rs2 != 5'd0) && (sb_q[rs2] || (valid_q && (rd_q == rs2)));
    assign hazard   = if_valid && ((use_rs1 && rs1_busy) || (use_rs2 && rs2_busy));
    assign load     = !valid_q || ex_ready;
    assign id_ready = reset_n && load && !hazard && !flush;
    assign issue    = if_valid && id_ready;
    assign sb_set   = valid_q && ex_ready && !flush && !ill_q && (rd_q != 5'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q  <= 1'b0;
            alu_op_q <= ALU_NONE;
            imm_q    <= '0;
            a_imm_q  <= 1'b0;
            rd_q     <= '0;
            pc_q     <= '0;
            ill_q    <= 1'b0;
            ra0_q    <= '0;
            ra1_q    <= '0;
        end else if (flush) begin
            valid_q  <= 1'b0;
            alu_op_q <= ALU_NONE;
            ill_q    <= 1'b0;
        end else if (issue) begin
            valid_q  <= 1'b1;
            alu_op_q <= dec_op;
            imm_q    <= dec_imm;
            a_imm_q  <= dec_a_imm;
            rd_q     <= dec_rd;
            pc_q     <= if_pc;
            ill_q    <= dec_ill;
            ra0_q    <= use_rs1 ? rs1 : 5'd0;
            ra1_q    <= use_rs2 ? rs2 : 5'd0;
        end else if (load) begin
            valid_q  <= 1'b0;
            alu_op_q <= ALU_NONE;
            ill_q    <= 1'b0;
        end
    end

    // Set is applied after clear so a same-cycle retire/hand-off leaves the register pending.
    always_comb begin
        sb_d = sb_q;
        if (wb_valid && (wb_rd != 5'd0)) sb_d[wb_rd] = 1'b0;
        if (sb_set) sb_d[rd_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sb_q <= '0;
        else          sb_q <= sb_d;
    end

    assign id_ex_valid                = valid_q;
    assign id_ex_alu_op               = alu_op_q;
    assign id_ex_imm                  = imm_q;
    assign id_ex_input_a_is_immediate = a_imm_q;
    assign id_ex_rd                   = rd_q;
    assign id_ex_pc                   = pc_q;
    assign id_ex_illegal              = ill_q;
    assign regfile_rd0_addr           = ra0_q;
    assign regfile_rd1_addr           = ra1_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus a randomized stream against a pipeline-level reference model.
module tb_decode_stage;

    localparam logic [3:0] A_NONE = 4'd0, A_ADD = 4'd1, A_SUB = 4'd2, A_AND = 4'd3, A_OR = 4'd4,
                           A_XOR = 4'd5, A_SLL = 4'd6, A_SRL = 4'd7, A_SRA = 4'd8, A_SLT = 4'd9,
                           A_SLTU = 4'd10;
    // ALU op by funct3 for the base (funct7 = 0) encodings.
    localparam logic [3:0] F3_OP [8] = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};

    typedef struct packed {
        logic        ill;
        logic [3:0]  op;
        logic [31:0] imm;
        logic        a_imm;
        logic [4:0]  rd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
    } dec_t;

    logic        clk, reset_n, if_valid, flush, ex_ready, wb_valid;
    logic [31:0] if_instr, if_pc;
    logic [4:0]  wb_rd;
    logic        id_ready, id_ex_valid, id_ex_input_a_is_immediate, id_ex_illegal;
    logic [3:0]  id_ex_alu_op;
    logic [31:0] id_ex_imm, id_ex_pc;
    logic [4:0]  id_ex_rd, regfile_rd0_addr, regfile_rd1_addr;
    logic [85:0] obs;

    int chk_cnt;
    int pass_cnt;

    decode_stage #(.XLEN(32), .NREGS(32)) dut (
        .clk(clk), .reset_n(reset_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .id_ex_valid(id_ex_valid), .id_ex_alu_op(id_ex_alu_op), .id_ex_imm(id_ex_imm),
        .id_ex_input_a_is_immediate(id_ex_input_a_is_immediate), .id_ex_rd(id_ex_rd),
        .id_ex_pc(id_ex_pc), .id_ex_illegal(id_ex_illegal),
        .regfile_rd0_addr(regfile_rd0_addr), .regfile_rd1_addr(regfile_rd1_addr)
    );

    assign obs = {id_ex_valid, id_ex_illegal, id_ex_alu_op, id_ex_imm, id_ex_input_a_is_immediate,
                  id_ex_rd, id_ex_pc, regfile_rd0_addr, regfile_rd1_addr};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic dec_t mk(input logic ill, input logic [3:0] op, input logic [31:0] imm,
                                input logic a_imm, input logic [4:0] rd, input logic [4:0] ra0,
                                input logic [4:0] ra1);
        dec_t e;
        e = '{ill: ill, op: op, imm: imm, a_imm: a_imm, rd: rd, ra0: ra0, ra1: ra1};
        return e;
    endfunction

    function automatic logic [85:0] pack(input logic v, input dec_t e, input logic [31:0] pc);
        return {v, e.ill, e.op, e.imm, e.a_imm, e.rd, pc, e.ra0, e.ra1};
    endfunction

    function automatic dec_t ref_decode(input logic [31:0] ins);
        dec_t e;
        logic [6:0] opc, f7;
        logic [2:0] f3;
        logic is_shift;
        e = '0;
        e.ill = 1'b1;
        opc = ins[6:0];
        f7 = ins[31:25];
        f3 = ins[14:12];
        is_shift = (f3 == 3'd1) || (f3 == 3'd5);
        if (opc == 7'h13) begin
            if (!is_shift || f7 == 7'h00 || f7 == 7'h20) begin
                e.ill   = 1'b0;
                e.op    = (f3 == 3'd5 && ins[30]) ? A_SRA : F3_OP[f3];
                e.imm   = is_shift ? {27'd0, ins[24:20]} : {{20{ins[31]}}, ins[31:20]};
                e.a_imm = 1'b1;
                e.rd    = ins[11:7];
                e.ra0   = ins[19:15];
            end
        end else if (opc == 7'h33) begin
            if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
                e.ill = 1'b0;
                e.op  = (f7 == 7'h20) ? ((f3 == 3'd0) ? A_SUB : A_SRA) : F3_OP[f3];
                e.rd  = ins[11:7];
                e.ra0 = ins[19:15];
                e.ra1 = ins[24:20];
            end
        end else if (opc == 7'h37) begin
            e.ill   = 1'b0;
            e.op    = A_ADD;
            e.imm   = {ins[31:12], 12'd0};
            e.a_imm = 1'b1;
            e.rd    = ins[11:7];
        end
        return e;
    endfunction

    function automatic logic busy(input logic [4:0] r, input logic [31:0] pend,
                                  input logic vld, input logic [4:0] prd);
        return (r != 5'd0) && (pend[r] || (vld && prd == r));
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r, ins;
        logic [6:0]  f7, opc;
        logic [2:0]  f3;
        logic [4:0]  rs1, rs2, rd;
        r   = $urandom;
        f3  = r[14:12];
        f7  = r[31:25];
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 7))
            0, 1, 2, 7: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    case ($urandom_range(0, 3))
                        0, 1:    f7 = 7'h00;
                        2:       f7 = 7'h20;
                        default: f7 = r[31:25];
                    endcase
                end
                ins = {f7, r[24:20], rs1, f3, rd, 7'h13};
            end
            3, 4: begin
                case ($urandom_range(0, 2))
                    0:       f7 = 7'h00;
                    1:       f7 = 7'h20;
                    default: f7 = 7'h01;
                endcase
                ins = {f7, rs2, rs1, f3, rd, 7'h33};
            end
            5: ins = {r[31:12], rd, 7'h37};
            default: begin
                case ($urandom_range(0, 3))
                    0:       opc = 7'h03;
                    1:       opc = 7'h63;
                    2:       opc = 7'h6F;
                    default: opc = 7'h7F;
                endcase
                ins = {r[31:12], rd, opc};
            end
        endcase
        return ins;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
        flush = 1'b0; ex_ready = 1'b0; wb_valid = 1'b0; wb_rd = '0;
        tick();
        tick();
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        chk_cnt++;
        if (obs !== 86'd0 || id_ready !== 1'b1) $display("FAIL reset_idle obs=%h rdy=%b exp obs=0 rdy=1", obs, id_ready);
        else pass_cnt++;
        if_valid = 1'b1; if_instr = 32'hFFB00093; if_pc = 32'h40; ex_ready = 1'b1;
        tick();
        if_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk_cnt++;
        if (obs !== 86'd0 || id_ready !== 1'b0) $display("FAIL reset_async obs=%h rdy=%b exp obs=0 rdy=0", obs, id_ready);
        else pass_cnt++;
        tick();
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_decode_basic();
        do_reset();
        ex_ready = 1'b1; if_valid = 1'b1; if_instr = 32'hFFB00093; if_pc = 32'h100;
        #1;
        chk_cnt++;
        if (id_ready !== 1'b1) $display("FAIL basic_ready got=%b exp=1", id_ready);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (obs !== pack(1'b1, mk(0, A_ADD, 32'hFFFFFFFB, 1, 5'd1, 5'd0, 5'd0), 32'h100))
            $display("FAIL basic_addi got=%h exp=%h", obs, pack(1'b1, mk(0, A_ADD, 32'hFFFFFFFB, 1, 5'd1, 5'd0, 5'd0), 32'h100));
        else pass_cnt++;
        if_instr = 32'h4041D113; if_pc = 32'h104;
        tick();
        chk_cnt++;
        if (obs !== pack(1'b1, mk(0, A_SRA, 32'd4, 1, 5'd2, 5'd3, 5'd0), 32'h104))
            $display("FAIL basic_srai got=%h exp=%h", obs, pack(1'b1, mk(0, A_SRA, 32'd4, 1, 5'd2, 5'd3, 5'd0), 32'h104));
        else pass_cnt++;
        if_instr = 32'h123452B7; if_pc = 32'h108;
        tick();
        chk_cnt++;
        if (obs !== pack(1'b1, mk(0, A_ADD, 32'h12345000, 1, 5'd5, 5'd0, 5'd0), 32'h108))
            $display("FAIL basic_lui got=%h exp=%h", obs, pack(1'b1, mk(0, A_ADD, 32'h12345000, 1, 5'd5, 5'd0, 5'd0), 32'h108));
        else pass_cnt++;
        if_instr = 32'h0000007F; if_pc = 32'h10C;
        tick();
        chk_cnt++;
        if (id_ex_valid !== 1'b1 || id_ex_illegal !== 1'b1 || id_ex_alu_op !== A_NONE || id_ex_rd !== 5'd0)
            $display("FAIL basic_illegal got v=%b ill=%b op=%0d rd=%0d exp v=1 ill=1 op=0 rd=0",
                     id_ex_valid, id_ex_illegal, id_ex_alu_op, id_ex_rd);
        else pass_cnt++;
        if_valid = 1'b0;
        tick();
        chk_cnt++;
        if ({id_ex_valid, id_ex_illegal, id_ex_alu_op} !== {1'b0, 1'b0, A_NONE})
            $display("FAIL basic_bubble got v=%b ill=%b op=%0d exp 0/0/0", id_ex_valid, id_ex_illegal, id_ex_alu_op);
        else pass_cnt++;
    endtask

    task automatic test_raw_stall();
        do_reset();
        ex_ready = 1'b1; if_valid = 1'b1; if_instr = 32'hFFB00093; if_pc = 32'h300;
        tick();
        if_instr = 32'h002081B3; if_pc = 32'h304;
        #1;
        chk_cnt++;
        if (id_ready !== 1'b0) $display("FAIL raw_ready_idex got=%b exp=0", id_ready);
        else pass_cnt++;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk_cnt++;
            if (id_ready !== 1'b0 || id_ex_valid !== 1'b0)
                $display("FAIL raw_stall cyc=%0d got rdy=%b v=%b exp rdy=0 v=0", i, id_ready, id_ex_valid);
            else pass_cnt++;
            tick();
        end
        wb_valid = 1'b1; wb_rd = 5'd1;
        #1;
        chk_cnt++;
        if (id_ready !== 1'b0) $display("FAIL raw_no_bypass got=%b exp=0", id_ready);
        else pass_cnt++;
        tick();
        wb_valid = 1'b0; wb_rd = 5'd0;
        #1;
        chk_cnt++;
        if (id_ready !== 1'b1) $display("FAIL raw_retired_ready got=%b exp=1", id_ready);
        else pass_cnt++;
        tick();
        if_valid = 1'b0;
        chk_cnt++;
        if (obs !== pack(1'b1, mk(0, A_ADD, 32'd0, 0, 5'd3, 5'd1, 5'd2), 32'h304))
            $display("FAIL raw_issue got=%h exp=%h", obs, pack(1'b1, mk(0, A_ADD, 32'd0, 0, 5'd3, 5'd1, 5'd2), 32'h304));
        else pass_cnt++;
    endtask

    task automatic test_hold();
        do_reset();
        ex_ready = 1'b0; if_valid = 1'b1; if_instr = 32'h00700213; if_pc = 32'h200;
        tick();
        if_instr = 32'h05506313; if_pc = 32'h204;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_cnt++;
            if (id_ready !== 1'b0) $display("FAIL hold_ready cyc=%0d got=%b exp=0", i, id_ready);
            else pass_cnt++;
            tick();
            chk_cnt++;
            if (obs !== pack(1'b1, mk(0, A_ADD, 32'd7, 1, 5'd4, 5'd0, 5'd0), 32'h200))
                $display("FAIL hold_stable cyc=%0d got=%h exp=%h", i, obs, pack(1'b1, mk(0, A_ADD, 32'd7, 1, 5'd4, 5'd0, 5'd0), 32'h200));
            else pass_cnt++;
        end
        ex_ready = 1'b1;
        #1;
        chk_cnt++;
        if (id_ready !== 1'b1) $display("FAIL hold_release_ready got=%b exp=1", id_ready);
        else pass_cnt++;
        tick();
        if_valid = 1'b0;
        chk_cnt++;
        if (obs !== pack(1'b1, mk(0, A_OR, 32'h55, 1, 5'd6, 5'd0, 5'd0), 32'h204))
            $display("FAIL hold_next got=%h exp=%h", obs, pack(1'b1, mk(0, A_OR, 32'h55, 1, 5'd6, 5'd0, 5'd0), 32'h204));
        else pass_cnt++;
    endtask

    task automatic test_flush();
        do_reset();
        ex_ready = 1'b1; if_valid = 1'b1; if_instr = 32'h00700213; if_pc = 32'h400;
        tick();
        if_instr = 32'h004202B3; if_pc = 32'h404; flush = 1'b1;
        #1;
        chk_cnt++;
        if (id_ready !== 1'b0) $display("FAIL flush_ready got=%b exp=0", id_ready);
        else pass_cnt++;
        tick();
        flush = 1'b0;
        chk_cnt++;
        if ({id_ex_valid, id_ex_illegal, id_ex_alu_op} !== {1'b0, 1'b0, A_NONE})
            $display("FAIL flush_bubble got v=%b ill=%b op=%0d exp 0/0/0", id_ex_valid, id_ex_illegal, id_ex_alu_op);
        else pass_cnt++;
        #1;
        chk_cnt++;
        if (id_ready !== 1'b1) $display("FAIL flush_no_sb got=%b exp=1", id_ready);
        else pass_cnt++;
        tick();
        if_valid = 1'b0;
        chk_cnt++;
        if (obs !== pack(1'b1, mk(0, A_ADD, 32'd0, 0, 5'd5, 5'd4, 5'd4), 32'h404))
            $display("FAIL flush_then_add got=%h exp=%h", obs, pack(1'b1, mk(0, A_ADD, 32'd0, 0, 5'd5, 5'd4, 5'd4), 32'h404));
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        ex_ready = 1'b1; if_valid = 1'b1; if_instr = 32'hFFB00093; if_pc = 32'h500;
        tick();
        if_instr = 32'h002081B3; if_pc = 32'h504;
        tick();
        chk_cnt++;
        if (id_ready !== 1'b0) $display("FAIL rst_stall_ready got=%b exp=0", id_ready);
        else pass_cnt++;
        reset_n = 1'b0;
        #1;
        chk_cnt++;
        if (obs !== 86'd0 || id_ready !== 1'b0) $display("FAIL rst_stall_clear obs=%h rdy=%b exp obs=0 rdy=0", obs, id_ready);
        else pass_cnt++;
        tick();
        reset_n = 1'b1;
        #1;
        chk_cnt++;
        if (id_ready !== 1'b1) $display("FAIL rst_release_ready got=%b exp=1", id_ready);
        else pass_cnt++;
        tick();
        if_valid = 1'b0;
        chk_cnt++;
        if (obs !== pack(1'b1, mk(0, A_ADD, 32'd0, 0, 5'd3, 5'd1, 5'd2), 32'h504))
            $display("FAIL rst_release_issue got=%h exp=%h", obs, pack(1'b1, mk(0, A_ADD, 32'd0, 0, 5'd3, 5'd1, 5'd2), 32'h504));
        else pass_cnt++;
    endtask

    task automatic test_random_stream();
        dec_t        d, m_e;
        logic        m_vld, hold, exp_rdy, handoff;
        logic [31:0] m_pc, pend, cur;
        int          rq[$];
        do_reset();
        m_vld = 1'b0; m_e = '0; m_pc = '0; pend = '0; hold = 1'b0; cur = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!hold) begin
                cur      = rand_instr();
                if_valid = ($urandom_range(0, 3) != 0);
                if_pc    = $urandom & 32'hFFFF_FFFC;
            end
            if_instr = cur;
            flush    = ($urandom_range(0, 15) == 0);
            ex_ready = ($urandom_range(0, 3) != 0);
            wb_valid = 1'b0;
            wb_rd    = 5'd0;
            if (rq.size() > 0 && $urandom_range(0, 2) == 0) begin
                wb_valid = 1'b1;
                wb_rd    = 5'(rq.pop_front());
            end
            #1;
            d = ref_decode(cur);
            exp_rdy = !flush && (!m_vld || ex_ready) &&
                      !(if_valid && (busy(d.ra0, pend, m_vld, m_e.rd) || busy(d.ra1, pend, m_vld, m_e.rd)));
            chk_cnt++;
            if (id_ready !== exp_rdy)
                $display("FAIL rnd_ready cyc=%0d instr=%h got=%b exp=%b", cyc, cur, id_ready, exp_rdy);
            else pass_cnt++;

            handoff = m_vld && ex_ready && !flush;
            if (wb_valid && wb_rd != 5'd0) pend[wb_rd] = 1'b0;
            if (handoff && !m_e.ill && m_e.rd != 5'd0) begin
                pend[m_e.rd] = 1'b1;
                rq.push_back(int'(m_e.rd));
            end
            if (flush) begin
                m_vld = 1'b0; m_e.op = A_NONE; m_e.ill = 1'b0;
            end else if (if_valid && exp_rdy) begin
                m_vld = 1'b1; m_e = d; m_pc = if_pc;
            end else if (!m_vld || ex_ready) begin
                m_vld = 1'b0; m_e.op = A_NONE; m_e.ill = 1'b0;
            end
            hold = if_valid && !exp_rdy;
            tick();
            chk_cnt++;
            if (obs !== pack(m_vld, m_e, m_pc))
                $display("FAIL rnd_out cyc=%0d got=%h exp=%h", cyc, obs, pack(m_vld, m_e, m_pc));
            else pass_cnt++;
        end
        if_valid = 1'b0; flush = 1'b0; wb_valid = 1'b0;
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        test_reset();
        test_decode_basic();
        test_raw_stall();
        test_hold();
        test_flush();
        test_reset_mid_stall();
        test_random_stream();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
